// File: rtl/ram_arbiter_nch_if.sv
// Client request/ack bus and RAM read/write ports of the N-client RAM arbiter.
interface ram_arbiter_nch_if #(
    parameter int G_ADDR_WIDTH  = 4,
    parameter int G_DATA_WIDTH  = 8,
    parameter int G_NUM_CLIENTS = 4
);
    localparam int AW = G_ADDR_WIDTH;
    localparam int DW = G_DATA_WIDTH;
    localparam int N  = G_NUM_CLIENTS;

    logic [N-1:0]    REQ;
    logic [N-1:0]    RD_NOT_WRITE;
    logic [N*AW-1:0] ADDR;
    logic [N*DW-1:0] WRDATA;
    logic [N-1:0]    ACK;
    logic [N-1:0]    RDVALID;
    logic [DW-1:0]   RDDATA;
    logic            RD_EN;
    logic [AW-1:0]   RD_ADDR;
    logic [DW-1:0]   RD_DATA;
    logic            WR_EN;
    logic [AW-1:0]   WR_ADDR;
    logic [DW-1:0]   WR_DATA;

    modport master (
        output REQ, RD_NOT_WRITE, ADDR, WRDATA, RD_DATA,
        input  ACK, RDVALID, RDDATA,
        input  RD_EN, RD_ADDR, WR_EN, WR_ADDR, WR_DATA
    );

    modport slave (
        input  REQ, RD_NOT_WRITE, ADDR, WRDATA, RD_DATA,
        output ACK, RDVALID, RDDATA,
        output RD_EN, RD_ADDR, WR_EN, WR_ADDR, WR_DATA
    );
endinterface

// File: rtl/ram_arbiter_nch.sv
// N-client arbiter for a 1R/1W RAM: independent read/write arbiters,
// post-reset memory clear, write-to-read forwarding, optional data register.
module ram_arbiter_nch #(
    parameter int G_ADDR_WIDTH      = 4,
    parameter int G_DATA_WIDTH      = 8,
    parameter int G_NUM_CLIENTS     = 4,
    parameter int G_ROUND_ROBIN     = 1,
    parameter int G_REGISTERED_DATA = 0
) (
    input  logic             CLOCK,
    input  logic             RST,
    output logic             RST_DONE,
    ram_arbiter_nch_if.slave bus
);
    localparam int AW = G_ADDR_WIDTH;
    localparam int DW = G_DATA_WIDTH;
    localparam int N  = G_NUM_CLIENTS;
    localparam int PW = $clog2(N);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] clr_cnt;
    logic          run;

    logic [N-1:0]  ack_q;
    logic          rd_en_q;
    logic [AW-1:0] rd_addr_q;
    logic [PW-1:0] rd_idx_q;
    logic          wr_en_q;
    logic [AW-1:0] wr_addr_q;
    logic [DW-1:0] wr_data_q;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    logic [N-1:0]  rd_elig;
    logic [N-1:0]  wr_elig;
    logic [PW:0]   rd_pick;
    logic [PW:0]   wr_pick;
    logic          rd_go;
    logic          wr_go;
    logic [PW-1:0] rd_k;
    logic [PW-1:0] wr_k;

    logic          rv1;
    logic [PW-1:0] ridx1;
    logic          clash1;
    logic [DW-1:0] fwd1;
    logic [DW-1:0] rdata_sel;

    // First eligible index at or after start, wrapping modulo N.
    function automatic logic [PW:0] pick(
        input logic [N-1:0]  elig,
        input logic [PW-1:0] start
    );
        logic [PW:0] r;
        int          j;
        r = '0;
        for (int off = N - 1; off >= 0; off--) begin
            j = int'(start) + off;
            if (j >= N) j -= N;
            if (elig[j]) r = {1'b1, PW'(j)};
        end
        return r;
    endfunction

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] k);
        return (k == PW'(N - 1)) ? '0 : k + 1'b1;
    endfunction

    function automatic logic [N-1:0] onehot(input logic [PW-1:0] k);
        return {{(N-1){1'b0}}, 1'b1} << k;
    endfunction

    always_ff @(posedge CLOCK) begin
        if (RST) begin
            state   <= S_INIT;
            clr_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_INIT) clr_cnt <= clr_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_INIT: if (&clr_cnt) state_nxt = S_RUN;
            S_RUN:  state_nxt = S_RUN;
        endcase
    end

    // The clear sequence owns the write port until RUN.
    always_comb begin
        run      = (state == S_RUN);
        RST_DONE = run;
        if (run) begin
            bus.WR_EN   = wr_en_q;
            bus.WR_ADDR = wr_addr_q;
            bus.WR_DATA = wr_data_q;
        end else begin
            bus.WR_EN   = 1'b1;
            bus.WR_ADDR = clr_cnt;
            bus.WR_DATA = '0;
        end
    end

    always_comb begin
        rd_elig = bus.REQ & bus.RD_NOT_WRITE
                & ~ack_q & {N{run}};
        wr_elig = bus.REQ & ~bus.RD_NOT_WRITE
                & ~ack_q & {N{run}};
        rd_pick = pick(rd_elig,
                       (G_ROUND_ROBIN != 0) ? rd_ptr : PW'(0));
        wr_pick = pick(wr_elig,
                       (G_ROUND_ROBIN != 0) ? wr_ptr : PW'(0));
        {rd_go, rd_k} = rd_pick;
        {wr_go, wr_k} = wr_pick;
    end

    always_ff @(posedge CLOCK) begin
        if (RST) begin
            ack_q     <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            rd_idx_q  <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
        end else begin
            ack_q     <= (rd_go ? onehot(rd_k) : '0)
                       | (wr_go ? onehot(wr_k) : '0);
            rd_en_q   <= rd_go;
            rd_addr_q <= rd_go ? bus.ADDR[rd_k*AW +: AW] : '0;
            rd_idx_q  <= rd_k;
            wr_en_q   <= wr_go;
            wr_addr_q <= wr_go ? bus.ADDR[wr_k*AW +: AW] : '0;
            wr_data_q <= wr_go ? bus.WRDATA[wr_k*DW +: DW] : '0;
            if (rd_go) rd_ptr <= nxt(rd_k);
            if (wr_go) wr_ptr <= nxt(wr_k);
        end
    end

    assign bus.ACK     = ack_q;
    assign bus.RD_EN   = rd_en_q;
    assign bus.RD_ADDR = rd_addr_q;

    // Clash is judged on the issued RAM commands, write-first.
    always_ff @(posedge CLOCK) begin
        if (RST) begin
            rv1    <= 1'b0;
            ridx1  <= '0;
            clash1 <= 1'b0;
            fwd1   <= '0;
        end else begin
            rv1    <= rd_en_q;
            ridx1  <= rd_idx_q;
            clash1 <= rd_en_q & bus.WR_EN
                    & (rd_addr_q == bus.WR_ADDR);
            fwd1   <= bus.WR_DATA;
        end
    end

    assign rdata_sel = clash1 ? fwd1 : bus.RD_DATA;

    if (G_REGISTERED_DATA != 0) begin : g_reg
        logic          rv2;
        logic [PW-1:0] ridx2;
        logic [DW-1:0] rdata2;

        always_ff @(posedge CLOCK) begin
            if (RST) begin
                rv2    <= 1'b0;
                ridx2  <= '0;
                rdata2 <= '0;
            end else begin
                rv2   <= rv1;
                ridx2 <= ridx1;
                if (rv1) rdata2 <= rdata_sel;
            end
        end

        assign bus.RDVALID = rv2 ? onehot(ridx2) : '0;
        assign bus.RDDATA  = rdata2;
    end else begin : g_comb
        logic [DW-1:0] hold;

        always_ff @(posedge CLOCK) begin
            if (RST) hold <= '0;
            else if (rv1) hold <= rdata_sel;
        end

        assign bus.RDVALID = rv1 ? onehot(ridx1) : '0;
        assign bus.RDDATA  = rv1 ? rdata_sel : hold;
    end
endmodule

// File: tb/tb_ram_arbiter_nch.sv
// Directed bench: instance A round-robin/unregistered, B fixed/registered.
module tb_ram_arbiter_nch;
    localparam int AW = 4;
    localparam int DW = 8;
    localparam int N  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic done_a;
    logic done_b;
    int   n_cmp = 0;
    int   n_bad = 0;

    ram_arbiter_nch_if #(
        .G_ADDR_WIDTH(AW), .G_DATA_WIDTH(DW), .G_NUM_CLIENTS(N)
    ) ifa ();
    ram_arbiter_nch_if #(
        .G_ADDR_WIDTH(AW), .G_DATA_WIDTH(DW), .G_NUM_CLIENTS(N)
    ) ifb ();

    ram_arbiter_nch #(
        .G_ADDR_WIDTH(AW), .G_DATA_WIDTH(DW), .G_NUM_CLIENTS(N),
        .G_ROUND_ROBIN(1), .G_REGISTERED_DATA(0)
    ) u_a (
        .CLOCK(clk), .RST(rst), .RST_DONE(done_a), .bus(ifa)
    );

    ram_arbiter_nch #(
        .G_ADDR_WIDTH(AW), .G_DATA_WIDTH(DW), .G_NUM_CLIENTS(N),
        .G_ROUND_ROBIN(0), .G_REGISTERED_DATA(1)
    ) u_b (
        .CLOCK(clk), .RST(rst), .RST_DONE(done_b), .bus(ifb)
    );

    always #5 clk = ~clk;

    // Memories start dirty so an incomplete clear is visible.
    logic [DW-1:0] mem_a [2**AW] = '{default: 8'hEE};
    logic [DW-1:0] mem_b [2**AW] = '{default: 8'hEE};

    always @(posedge clk) begin
        if (ifa.WR_EN) mem_a[ifa.WR_ADDR] <= ifa.WR_DATA;
        if (ifa.RD_EN) ifa.RD_DATA <= mem_a[ifa.RD_ADDR];
        if (ifb.WR_EN) mem_b[ifb.WR_ADDR] <= ifb.WR_DATA;
        if (ifb.RD_EN) ifb.RD_DATA <= mem_b[ifb.RD_ADDR];
    end

    task automatic cli_a(input int i, input logic rd,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        ifa.REQ[i]            = 1'b1;
        ifa.RD_NOT_WRITE[i]   = rd;
        ifa.ADDR[i*AW +: AW]  = a;
        ifa.WRDATA[i*DW +: DW] = d;
    endtask

    task automatic cli_b(input int i, input logic rd,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        ifb.REQ[i]            = 1'b1;
        ifb.RD_NOT_WRITE[i]   = rd;
        ifb.ADDR[i*AW +: AW]  = a;
        ifb.WRDATA[i*DW +: DW] = d;
    endtask

    task automatic test_reset();
        logic [31:0] got;
        logic [31:0] exp;
        ifa.REQ = '0; ifa.RD_NOT_WRITE = '0;
        ifa.ADDR = '0; ifa.WRDATA = '0;
        ifb.REQ = '0; ifb.RD_NOT_WRITE = '0;
        ifb.ADDR = '0; ifb.WRDATA = '0;
        @(negedge clk);
        rst = 1'b1;
        cli_a(0, 1'b1, 4'd5, 8'h00);
        @(negedge clk);
        got = {done_a, ifa.ACK, ifa.RDVALID, ifa.RDDATA, ifa.RD_EN,
               ifa.RD_ADDR, ifa.WR_EN, ifa.WR_ADDR, ifa.WR_DATA};
        exp = {1'b0, 4'h0, 4'h0, 8'h00, 1'b0,
               4'h0, 1'b1, 4'h0, 8'h00};
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL reset_vals_a: got %h want %h", got, exp);
        end
        got = {done_b, ifb.ACK, ifb.RDVALID, ifb.RDDATA, ifb.RD_EN,
               ifb.RD_ADDR, ifb.WR_EN, ifb.WR_ADDR, ifb.WR_DATA};
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL reset_vals_b: got %h want %h", got, exp);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 16; k++) begin
            n_cmp++;
            if (ifa.WR_EN !== 1'b1 || ifa.WR_ADDR !== AW'(k)
                || ifa.WR_DATA !== 8'h00) begin
                n_bad++;
                $display("FAIL clear_wr[%0d]: got en=%b a=%0d d=%h want 1 %0d 00",
                         k, ifa.WR_EN, ifa.WR_ADDR, ifa.WR_DATA, k);
            end
            n_cmp++;
            if (ifa.ACK !== 4'h0 || ifa.RD_EN !== 1'b0 || done_a !== 1'b0) begin
                n_bad++;
                $display("FAIL clear_idle[%0d]: got ack=%b rd_en=%b done=%b want 0 0 0",
                         k, ifa.ACK, ifa.RD_EN, done_a);
            end
            @(negedge clk);
        end
        ifa.REQ = '0;
        n_cmp++;
        if (done_a !== 1'b1 || done_b !== 1'b1 || ifa.WR_EN !== 1'b0
            || ifa.ACK !== 4'h0) begin
            n_bad++;
            $display("FAIL clear_done: got done=%b%b wr_en=%b ack=%b want 11 0 0000",
                     done_a, done_b, ifa.WR_EN, ifa.ACK);
        end
    endtask

    task automatic test_rr_read();
        logic [N-1:0] exp_v;
        for (int i = 0; i < N; i++) cli_a(i, 1'b1, AW'(i + 4), 8'h00);
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            if (c < 8) begin
                n_cmp++;
                if (ifa.ACK !== 4'(1 << (c % 4)) || ifa.RD_EN !== 1'b1
                    || ifa.RD_ADDR !== AW'((c % 4) + 4)) begin
                    n_bad++;
                    $display("FAIL rr_grant[%0d]: got ack=%b en=%b a=%0d want %b 1 %0d",
                             c, ifa.ACK, ifa.RD_EN, ifa.RD_ADDR,
                             4'(1 << (c % 4)), (c % 4) + 4);
                end
            end else begin
                n_cmp++;
                if (ifa.ACK !== 4'h0 || ifa.RD_EN !== 1'b0
                    || ifa.RD_ADDR !== 4'h0) begin
                    n_bad++;
                    $display("FAIL rr_idle: got ack=%b en=%b a=%0d want 0000 0 0",
                             ifa.ACK, ifa.RD_EN, ifa.RD_ADDR);
                end
            end
            exp_v = (c == 0) ? 4'h0 : 4'(1 << ((c - 1) % 4));
            n_cmp++;
            if (ifa.RDVALID !== exp_v || ifa.RDDATA !== 8'h00) begin
                n_bad++;
                $display("FAIL rr_rdvalid[%0d]: got v=%b d=%h want %b 00",
                         c, ifa.RDVALID, ifa.RDDATA, exp_v);
            end
            if (c == 7) ifa.REQ = '0;
        end
    endtask

    task automatic test_forward();
        cli_a(0, 1'b0, 4'd7, 8'hA5);
        cli_a(2, 1'b1, 4'd7, 8'h00);
        @(negedge clk);
        n_cmp++;
        if (ifa.ACK !== 4'b0101 || ifa.RD_EN !== 1'b1 || ifa.RD_ADDR !== 4'd7
            || ifa.WR_EN !== 1'b1 || ifa.WR_ADDR !== 4'd7
            || ifa.WR_DATA !== 8'hA5) begin
            n_bad++;
            $display("FAIL fwd_cmd: got ack=%b r=%b/%0d w=%b/%0d/%h want 0101 1/7 1/7/a5",
                     ifa.ACK, ifa.RD_EN, ifa.RD_ADDR, ifa.WR_EN,
                     ifa.WR_ADDR, ifa.WR_DATA);
        end
        ifa.REQ = '0;
        @(negedge clk);
        n_cmp++;
        if (ifa.RDVALID !== 4'b0100 || ifa.RDDATA !== 8'hA5) begin
            n_bad++;
            $display("FAIL fwd_data: got v=%b d=%h want 0100 a5",
                     ifa.RDVALID, ifa.RDDATA);
        end
        cli_a(2, 1'b1, 4'd7, 8'h00);
        @(negedge clk);
        ifa.REQ = '0;
        @(negedge clk);
        n_cmp++;
        if (ifa.RDVALID !== 4'b0100 || ifa.RDDATA !== 8'hA5) begin
            n_bad++;
            $display("FAIL fwd_reread: got v=%b d=%h want 0100 a5",
                     ifa.RDVALID, ifa.RDDATA);
        end
        cli_a(1, 1'b0, 4'd2, 8'h3C);
        cli_a(3, 1'b1, 4'd7, 8'h00);
        @(negedge clk);
        n_cmp++;
        if (ifa.ACK !== 4'b1010 || ifa.WR_ADDR !== 4'd2
            || ifa.WR_DATA !== 8'h3C || ifa.RD_ADDR !== 4'd7) begin
            n_bad++;
            $display("FAIL nclash_cmd: got ack=%b wa=%0d wd=%h ra=%0d want 1010 2 3c 7",
                     ifa.ACK, ifa.WR_ADDR, ifa.WR_DATA, ifa.RD_ADDR);
        end
        ifa.REQ = '0;
        @(negedge clk);
        n_cmp++;
        if (ifa.RDVALID !== 4'b1000 || ifa.RDDATA !== 8'hA5) begin
            n_bad++;
            $display("FAIL nclash_data: got v=%b d=%h want 1000 a5",
                     ifa.RDVALID, ifa.RDDATA);
        end
        cli_a(0, 1'b1, 4'd2, 8'h00);
        @(negedge clk);
        ifa.REQ = '0;
        @(negedge clk);
        n_cmp++;
        if (ifa.RDVALID !== 4'b0001 || ifa.RDDATA !== 8'h3C) begin
            n_bad++;
            $display("FAIL wr_then_rd: got v=%b d=%h want 0001 3c",
                     ifa.RDVALID, ifa.RDDATA);
        end
        @(negedge clk);
        n_cmp++;
        if (ifa.RDVALID !== 4'h0 || ifa.RDDATA !== 8'h3C) begin
            n_bad++;
            $display("FAIL rddata_hold: got v=%b d=%h want 0000 3c",
                     ifa.RDVALID, ifa.RDDATA);
        end
    endtask

    task automatic test_fixed();
        logic [N-1:0]  e_ack;
        logic [N-1:0]  e_v;
        logic [AW-1:0] e_a;
        logic [DW-1:0] e_d;
        cli_b(1, 1'b0, 4'd1, 8'h11);
        cli_b(3, 1'b0, 4'd3, 8'h33);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            e_ack = (c % 2 == 0) ? 4'b0010 : 4'b1000;
            e_a   = (c % 2 == 0) ? 4'd1 : 4'd3;
            e_d   = (c % 2 == 0) ? 8'h11 : 8'h33;
            n_cmp++;
            if (ifb.ACK !== e_ack || ifb.WR_EN !== 1'b1
                || ifb.WR_ADDR !== e_a || ifb.WR_DATA !== e_d) begin
                n_bad++;
                $display("FAIL fix_wr[%0d]: got ack=%b a=%0d d=%h want %b %0d %h",
                         c, ifb.ACK, ifb.WR_ADDR, ifb.WR_DATA, e_ack, e_a, e_d);
            end
        end
        ifb.REQ = '0;
        cli_b(0, 1'b1, 4'd1, 8'h00);
        cli_b(1, 1'b1, 4'd3, 8'h00);
        cli_b(2, 1'b1, 4'd5, 8'h00);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            e_ack = (c >= 6) ? 4'h0 : (c % 2 == 0) ? 4'b0001 : 4'b0010;
            e_a   = (c >= 6) ? 4'd0 : (c % 2 == 0) ? 4'd1 : 4'd3;
            n_cmp++;
            if (ifb.ACK !== e_ack || ifb.RD_ADDR !== e_a) begin
                n_bad++;
                $display("FAIL fix_rd[%0d]: got ack=%b a=%0d want %b %0d",
                         c, ifb.ACK, ifb.RD_ADDR, e_ack, e_a);
            end
            e_v = (c < 2) ? 4'h0 : (c % 2 == 0) ? 4'b0001 : 4'b0010;
            n_cmp++;
            if (ifb.RDVALID !== e_v) begin
                n_bad++;
                $display("FAIL reg_valid[%0d]: got %b want %b",
                         c, ifb.RDVALID, e_v);
            end
            if (c >= 2) begin
                e_d = (c % 2 == 0) ? 8'h11 : 8'h33;
                n_cmp++;
                if (ifb.RDDATA !== e_d) begin
                    n_bad++;
                    $display("FAIL reg_data[%0d]: got %h want %h",
                             c, ifb.RDDATA, e_d);
                end
            end
            if (c == 5) ifb.REQ = '0;
        end
    endtask

    task automatic test_registered_clash();
        cli_b(0, 1'b0, 4'd9, 8'h5A);
        cli_b(2, 1'b1, 4'd9, 8'h00);
        @(negedge clk);
        n_cmp++;
        if (ifb.ACK !== 4'b0101) begin
            n_bad++;
            $display("FAIL rclash_ack: got %b want 0101", ifb.ACK);
        end
        ifb.REQ = '0;
        @(negedge clk);
        n_cmp++;
        if (ifb.RDVALID !== 4'h0) begin
            n_bad++;
            $display("FAIL rclash_early: got %b want 0000", ifb.RDVALID);
        end
        @(negedge clk);
        n_cmp++;
        if (ifb.RDVALID !== 4'b0100 || ifb.RDDATA !== 8'h5A) begin
            n_bad++;
            $display("FAIL rclash_data: got v=%b d=%h want 0100 5a",
                     ifb.RDVALID, ifb.RDDATA);
        end
        @(negedge clk);
        n_cmp++;
        if (ifb.RDVALID !== 4'h0 || ifb.RDDATA !== 8'h5A) begin
            n_bad++;
            $display("FAIL rclash_hold: got v=%b d=%h want 0000 5a",
                     ifb.RDVALID, ifb.RDDATA);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] got;
        logic [31:0] exp;
        cli_a(1, 1'b1, 4'd7, 8'h00);
        @(negedge clk);
        n_cmp++;
        if (ifa.ACK !== 4'b0010 || ifa.RD_EN !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_grant: got ack=%b en=%b want 0010 1",
                     ifa.ACK, ifa.RD_EN);
        end
        rst = 1'b1;
        ifa.REQ = '0;
        @(negedge clk);
        got = {done_a, ifa.ACK, ifa.RDVALID, ifa.RDDATA, ifa.RD_EN,
               ifa.RD_ADDR, ifa.WR_EN, ifa.WR_ADDR, ifa.WR_DATA};
        exp = {1'b0, 4'h0, 4'h0, 8'h00, 1'b0,
               4'h0, 1'b1, 4'h0, 8'h00};
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL mid_reset_vals: got %h want %h", got, exp);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (ifa.RDVALID !== 4'h0 || ifa.WR_ADDR !== 4'd1 || ifa.WR_EN !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_restart: got v=%b wa=%0d we=%b want 0000 1 1",
                     ifa.RDVALID, ifa.WR_ADDR, ifa.WR_EN);
        end
        repeat (15) @(negedge clk);
        n_cmp++;
        if (done_a !== 1'b1 || done_b !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_done: got %b%b want 11", done_a, done_b);
        end
        cli_a(1, 1'b1, 4'd7, 8'h00);
        @(negedge clk);
        ifa.REQ = '0;
        @(negedge clk);
        n_cmp++;
        if (ifa.RDVALID !== 4'b0010 || ifa.RDDATA !== 8'h00) begin
            n_bad++;
            $display("FAIL mid_recleared: got v=%b d=%h want 0010 00",
                     ifa.RDVALID, ifa.RDDATA);
        end
    endtask

    initial begin
        test_reset();
        test_rr_read();
        test_forward();
        test_fixed();
        test_registered_clash();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
